// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: control bundle between the multi-cycle sequencer and the MIPS datapath
interface mc_ctrl_if;
  logic [5:0]  Op;
  logic [5:0]  Funct;
  logic        Zero;
  logic        mem_ready;
  logic        PCWr;
  logic [1:0]  PCsel;
  logic        IRWr;
  logic        RFWr;
  logic [1:0]  RegDst;
  logic [1:0]  MemtoReg;
  logic        DMRd;
  logic        DMWr;
  logic        ALUSrcB;
  logic        illegal;
  logic        bus_err;
  logic [2:0]  state;
  logic [31:0] retired;
  modport master (
    input  Op, Funct, Zero, mem_ready,
    output PCWr, PCsel, IRWr, RFWr, RegDst, MemtoReg, DMRd, DMWr, ALUSrcB,
           illegal, bus_err, state, retired
  );
  modport slave (
    output Op, Funct, Zero, mem_ready,
    input  PCWr, PCsel, IRWr, RFWr, RegDst, MemtoReg, DMRd, DMWr, ALUSrcB,
           illegal, bus_err, state, retired
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: 8-state multi-cycle MIPS sequencer with memory-wait timeout
// and retired-instruction counter.
module mc_ctrl_fsm #(
  parameter int TMO_W   = 4,
  parameter int TMO_MAX = 15
) (
  input  logic      clk,
  input  logic      rst,
  mc_ctrl_if.master io_bus
);
  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM_RD = 3'd3;
  localparam logic [2:0] MEM_WR = 3'd4;
  localparam logic [2:0] WB     = 3'd5;
  localparam logic [2:0] BRANCH = 3'd6;
  localparam logic [2:0] JUMP   = 3'd7;
  logic [2:0]       r_state, w_next;
  logic [TMO_W-1:0] r_cnt;
  logic [31:0]      r_retired;
  logic w_rtype, w_jr, w_jalr, w_lw, w_sw, w_beq, w_bne, w_j, w_jal, w_ialu;
  logic w_alu, w_br, w_jmp, w_link, w_mem, w_tmo, w_retire;
  assign w_rtype = io_bus.Op == 6'b000000 && io_bus.Funct != 6'b001000 && io_bus.Funct != 6'b001001;
  assign w_jr    = io_bus.Op == 6'b000000 && io_bus.Funct == 6'b001000;
  assign w_jalr  = io_bus.Op == 6'b000000 && io_bus.Funct == 6'b001001;
  assign w_lw    = io_bus.Op == 6'b100011;
  assign w_sw    = io_bus.Op == 6'b101011;
  assign w_beq   = io_bus.Op == 6'b000100;
  assign w_bne   = io_bus.Op == 6'b000101;
  assign w_j     = io_bus.Op == 6'b000010;
  assign w_jal   = io_bus.Op == 6'b000011;
  assign w_ialu  = io_bus.Op inside {6'b001000, 6'b001001, 6'b001010, 6'b001100, 6'b001101, 6'b001111};
  assign w_alu   = w_rtype || w_ialu || w_lw || w_sw;
  assign w_br    = w_beq || w_bne;
  assign w_jmp   = w_j || w_jal || w_jr || w_jalr;
  assign w_link  = w_jal || w_jalr;
  assign w_mem   = r_state == MEM_RD || r_state == MEM_WR;
  // A ready on the last allowed cycle wins over the timeout.
  assign w_tmo   = w_mem && !io_bus.mem_ready && r_cnt == TMO_W'(TMO_MAX);
  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:   w_next = DECODE;
      DECODE:  w_next = w_alu ? EXEC : w_br ? BRANCH : w_jmp ? JUMP : FETCH;
      EXEC:    w_next = w_lw ? MEM_RD : w_sw ? MEM_WR : WB;
      MEM_RD:  w_next = io_bus.mem_ready ? WB : w_tmo ? FETCH : MEM_RD;
      MEM_WR:  w_next = (io_bus.mem_ready || w_tmo) ? FETCH : MEM_WR;
      default: w_next = FETCH;
    endcase
  end
  assign w_retire = r_state == WB || r_state == BRANCH || r_state == JUMP ||
                    (r_state == MEM_WR && io_bus.mem_ready);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= FETCH;
      r_cnt     <= '0;
      r_retired <= '0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= (w_mem && w_next == r_state) ? r_cnt + 1'b1 : '0;
      r_retired <= r_retired + {31'd0, w_retire};
    end
  end
  // Strobes are gated by rst so an in-flight memory request drops immediately.
  assign io_bus.PCWr     = !rst && (r_state == FETCH || r_state == JUMP ||
                                    (r_state == BRANCH && (w_beq ? io_bus.Zero : !io_bus.Zero)));
  assign io_bus.PCsel    = r_state == BRANCH ? 2'd1 :
                           r_state == JUMP ? ((w_j || w_jal) ? 2'd2 : 2'd3) : 2'd0;
  assign io_bus.IRWr     = !rst && r_state == FETCH;
  assign io_bus.RFWr     = !rst && (r_state == WB || (r_state == JUMP && w_link));
  assign io_bus.RegDst   = r_state == WB ? (w_rtype ? 2'd1 : 2'd0) :
                           r_state == JUMP ? (w_jal ? 2'd2 : w_jalr ? 2'd1 : 2'd0) : 2'd0;
  assign io_bus.MemtoReg = (r_state == WB && w_lw) ? 2'd1 :
                           (r_state == JUMP && w_link) ? 2'd2 : 2'd0;
  assign io_bus.DMRd     = !rst && r_state == MEM_RD;
  assign io_bus.DMWr     = !rst && r_state == MEM_WR;
  assign io_bus.ALUSrcB  = (r_state == EXEC && (w_ialu || w_lw || w_sw)) || w_mem ||
                           (r_state == WB && w_lw);
  assign io_bus.illegal  = r_state == DECODE && !(w_alu || w_br || w_jmp);
  assign io_bus.bus_err  = w_tmo;
  assign io_bus.state    = r_state;
  assign io_bus.retired  = r_retired;
endmodule
